// File: rtl/rat_int_pkg.sv
// Shared definitions for the RAT MCU interrupt controller: FSM states,
// default port addresses and the in-service ID width.
package rat_int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  localparam int unsigned ID_W          = 3;
  localparam logic [7:0]  DEF_MASK_PORT = 8'h20;
  localparam logic [7:0]  DEF_PCLR_PORT = 8'h21;
  localparam logic [7:0]  DEF_EOI_PORT  = 8'h22;

endpackage

// File: rtl/rat_int_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 has the highest priority.
module prio_enc
  import rat_int_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (vec[i] && !valid) begin
        valid = 1'b1;
        idx   = i[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rat_int_ctrl.sv
// Prioritized interrupt controller driving INT_R of the RAT MCU.
// Optional macro INT_SYNC_EN adds a 2-flop synchronizer ahead of edge detection.
module rat_int_ctrl
  import rat_int_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [7:0]  MASK_PORT = DEF_MASK_PORT,
  parameter logic [7:0]  PCLR_PORT = DEF_PCLR_PORT,
  parameter logic [7:0]  EOI_PORT  = DEF_EOI_PORT
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  input  logic               INT_ACK,
  output logic               INT_R,
  output logic [ID_W-1:0]    ACTIVE_ID,
  output logic               IN_SERVICE,
  output logic [7:0]         RD_DATA,
  output logic               RD_HIT
);

  state_t             state;
  logic [NUM_SRC-1:0] irq_src, irq_q, rise;
  logic [NUM_SRC-1:0] pending, mask, eligible;
  logic [NUM_SRC-1:0] ack_clr, wr_clr;
  logic               wr_mask, wr_pclr, wr_eoi;
  logic               win_valid, ack_take;
  logic [ID_W-1:0]    win_idx;

`ifdef INT_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;

  always_ff @(posedge CLK) begin
    sync1 <= IRQ_IN;
    sync2 <= sync1;
  end

  always_comb irq_src = sync2;
`else
  always_comb irq_src = IRQ_IN;
`endif

  // Edge register keeps tracking the source through reset so a level held
  // across reset is not mistaken for a fresh rising edge afterwards.
  always_ff @(posedge CLK) begin
    irq_q <= irq_src;
  end

  always_comb begin
    rise     = irq_src & ~irq_q;
    eligible = pending & mask;
    wr_mask  = IO_STRB && (PORT_ID == MASK_PORT);
    wr_pclr  = IO_STRB && (PORT_ID == PCLR_PORT);
    wr_eoi   = IO_STRB && (PORT_ID == EOI_PORT);
    ack_take = (state == REQ) && INT_ACK && win_valid;
    // eligible & -eligible isolates the lowest set bit, i.e. the winner
    ack_clr  = ack_take ? (eligible & (~eligible + NUM_SRC'(1))) : '0;
    wr_clr   = wr_pclr ? OUT_PORT[NUM_SRC-1:0] : '0;
  end

  prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .vec   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      INT_R      <= 1'b0;
      IN_SERVICE <= 1'b0;
      ACTIVE_ID  <= '0;
      pending    <= '0;
      mask       <= '0;
    end else begin
      pending <= (pending & ~(wr_clr | ack_clr)) | rise;
      if (wr_mask) mask <= OUT_PORT[NUM_SRC-1:0];
      case (state)
        IDLE: begin
          if (win_valid) begin
            state <= REQ;
            INT_R <= 1'b1;
          end
        end
        REQ: begin
          if (!win_valid) begin
            state <= IDLE;
            INT_R <= 1'b0;
          end else if (INT_ACK) begin
            state      <= SERV;
            INT_R      <= 1'b0;
            IN_SERVICE <= 1'b1;
            ACTIVE_ID  <= win_idx;
          end
        end
        SERV: begin
          if (wr_eoi) begin
            state      <= IDLE;
            IN_SERVICE <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          INT_R      <= 1'b0;
          IN_SERVICE <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    RD_DATA = '0;
    RD_HIT  = 1'b0;
    if (PORT_ID == MASK_PORT) begin
      RD_HIT                 = 1'b1;
      RD_DATA[NUM_SRC-1:0]   = pending;
    end else if (PORT_ID == PCLR_PORT) begin
      RD_HIT  = 1'b1;
      RD_DATA = {IN_SERVICE, INT_R, 3'b000, ACTIVE_ID};
    end
  end

endmodule
